// File: rtl/div_result_fifo.sv
// Result FIFO for the serial divider: captures {quotient, remainder} on every
// rising edge of fini_i and exposes status, head and pop registers over Wishbone.
module div_result_fifo #(
  parameter int WBW   = 32,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             fini_i,
  input  logic [XLEN-1:0]  quotient_i,
  input  logic [XLEN-1:0]  remainder_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [WBW/8-1:0] wbs_sel_i,
  input  logic [WBW-1:0]   wbs_adr_i,
  input  logic [WBW-1:0]   wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [WBW-1:0]   wbs_dat_o,
  output logic             irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_HEAD_Q = 4'h4;
  localparam logic [3:0] OFF_HEAD_R = 4'h8;
  localparam logic [3:0] OFF_POP    = 4'hC;
  localparam logic [WBW-1:0] BAD_DATA = WBW'(32'h0bad_0bad);

  typedef struct packed {
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
  } result_t;

  result_t       mem [DEPTH];
  result_t       head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          fini_q;
  logic          overflow;
  logic          irq_en;

  logic           empty;
  logic           full;
  logic           hit;
  logic           access;
  logic           wr_access;
  logic           pop;
  logic           push;
  logic           do_push;
  logic           ovf_event;
  logic           ovf_clear;
  logic [3:0]     offset;
  logic [WBW-1:0] status;
  logic [WBW-1:0] rdata;

  // Byte selects and the undecoded address/data bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rd_ptr];
  assign offset = wbs_adr_i[3:0];

  // Partial decode: only the top nibble and address bits [7:4] select the block.
  assign hit       = (wbs_adr_i[WBW-1:WBW-4] == 4'h3) && (wbs_adr_i[7:4] == 4'h2);
  assign access    = hit && wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign wr_access = access && wbs_we_i;

  assign pop       = access && (offset == OFF_POP) && !empty;
  assign push      = fini_i && !fini_q;
  assign do_push   = push && (!full || pop);
  assign ovf_event = push && full && !pop;
  assign ovf_clear = wr_access && (offset == OFF_STATUS) && wbs_dat_i[8];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    status     = '0;
    status[4:0] = 5'(count);
    status[5]  = empty;
    status[6]  = full;
    status[8]  = overflow;
    status[16] = irq_en;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_STATUS: rdata = status;
      OFF_HEAD_Q: if (!empty) rdata = WBW'(head.quo);
      OFF_HEAD_R: if (!empty) rdata = WBW'(head.rem);
      OFF_POP:    rdata = '0;
      default:    rdata = BAD_DATA;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fini_q    <= 1'b0;
      overflow  <= 1'b0;
      irq_en    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      fini_q    <= fini_i;
      wbs_ack_o <= access;
      irq_o     <= irq_en && !empty;
      if (access && !wbs_we_i) wbs_dat_o <= rdata;
      if (wr_access && (offset == OFF_STATUS)) irq_en <= wbs_dat_i[16];
      // A drop in the same cycle as a W1C leaves the flag set.
      overflow <= ovf_event || (overflow && !ovf_clear);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= '{quo: quotient_i, rem: remainder_i};
  end

endmodule

// File: tb/tb_div_result_fifo.sv
// Bench for div_result_fifo: queue-based model compared every cycle, plus
// directed sequences with literal expectations and a randomized phase.
module tb_div_result_fifo;
  localparam int WBW   = 32;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            reset_ni = 1'b0;
  logic            fini_i = 1'b0;
  logic [XLEN-1:0] quotient_i = '0;
  logic [XLEN-1:0] remainder_i = '0;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'hF;
  logic [WBW-1:0]  wbs_adr_i = '0;
  logic [WBW-1:0]  wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [WBW-1:0]  wbs_dat_o;
  logic            irq_o;

  int checks = 0;
  int errors = 0;

  div_result_fifo #(.WBW(WBW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .fini_i(fini_i),
    .quotient_i(quotient_i), .remainder_i(remainder_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of results plus the few software-visible flags.
  logic [63:0] mq[$];
  logic        m_ack, m_irq, m_finiq, m_ovf, m_irqen;
  logic [31:0] m_dat;

  always @(posedge clk_i or negedge reset_ni) begin : model
    logic        acc, wr, emp, ful, pop, push;
    logic [31:0] rd;
    if (!reset_ni) begin
      mq.delete();
      m_ack <= 1'b0; m_irq <= 1'b0; m_finiq <= 1'b0;
      m_ovf <= 1'b0; m_irqen <= 1'b0; m_dat <= '0;
    end else begin
      emp  = (mq.size() == 0);
      ful  = (mq.size() == DEPTH);
      acc  = (wbs_adr_i[31:28] == 4'h3) && (wbs_adr_i[7:4] == 4'h2)
             && wbs_stb_i && wbs_cyc_i && !m_ack;
      wr   = acc && wbs_we_i;
      case (wbs_adr_i[3:0])
        4'h0:    rd = 32'(mq.size()) + (emp ? 32'h20 : 0) + (ful ? 32'h40 : 0)
                      + (m_ovf ? 32'h100 : 0) + (m_irqen ? 32'h1_0000 : 0);
        4'h4:    rd = emp ? 32'h0 : mq[0][63:32];
        4'h8:    rd = emp ? 32'h0 : mq[0][31:0];
        4'hC:    rd = 32'h0;
        default: rd = 32'h0bad_0bad;
      endcase
      pop  = acc && (wbs_adr_i[3:0] == 4'hC) && !emp;
      push = fini_i && !m_finiq;
      m_ack   <= acc;
      m_irq   <= m_irqen && !emp;
      m_finiq <= fini_i;
      if (acc && !wbs_we_i) m_dat <= rd;
      if (wr && wbs_adr_i[3:0] == 4'h0) m_irqen <= wbs_dat_i[16];
      if (push && ful && !pop) m_ovf <= 1'b1;
      else if (wr && wbs_adr_i[3:0] == 4'h0 && wbs_dat_i[8]) m_ovf <= 1'b0;
      if (pop) void'(mq.pop_front());
      if (push && (!ful || pop)) mq.push_back({quotient_i, remainder_i});
    end
  end

  always @(negedge clk_i) begin
    check("ack_vs_model", 32'(wbs_ack_o), 32'(m_ack));
    check("irq_vs_model", 32'(irq_o), 32'(m_irq));
    check("dat_vs_model", wbs_dat_o, m_dat);
  end

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd, output logic acked);
    acked = 1'b0;
    rd    = '0;
    @(negedge clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (wbs_ack_o) begin
        acked = 1'b1;
        rd    = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    wb_access(a, 1'b0, 32'h0, rd, ok);
    check({name, "_ack"}, 32'(ok), 32'h1);
    check(name, rd, exp);
  endtask

  task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        ok;
    wb_access(a, 1'b1, d, rd, ok);
    check({name, "_ack"}, 32'(ok), 32'h1);
  endtask

  task automatic wb_noack(input string name, input logic [31:0] a);
    logic [31:0] rd;
    logic        ok;
    wb_access(a, 1'b0, 32'h0, rd, ok);
    check(name, 32'(ok), 32'h0);
  endtask

  task automatic fini_pulse(input logic [31:0] q, input logic [31:0] r);
    @(negedge clk_i);
    fini_i = 1'b1; quotient_i = q; remainder_i = r;
    @(negedge clk_i);
    fini_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q[4];
    logic [3:0]  o;
    repeat (3) @(negedge clk_i);
    check("reset_ack", 32'(wbs_ack_o), 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    check("reset_dat", wbs_dat_o, 32'h0);
    reset_ni = 1'b1;

    // Address window
    wb_noack("noack_0x30", 32'h3000_0030);
    wb_noack("noack_0x34", 32'h3000_0034);
    wb_noack("noack_top2", 32'h2000_0020);
    wb_read("status_empty", 32'h3000_0020, 32'h0000_0020);

    // Single result
    fini_pulse(32'h10, 32'h3);
    wb_read("status_one", 32'h3000_0020, 32'h0000_0001);
    wb_read("head_q_one", 32'h3000_0024, 32'h10);
    wb_read("head_r_one", 32'h3000_0028, 32'h3);
    wb_write("pop_one", 32'h3000_002C, 32'h0);
    wb_read("status_drained", 32'h3000_0020, 32'h0000_0020);
    wb_read("head_q_empty", 32'h3000_0024, 32'h0);

    // Overflow after five results
    for (int i = 0; i < 5; i++) fini_pulse(32'h100 + i, 32'h200 + i);
    wb_read("status_ovf", 32'h3000_0020, 32'h0000_0144);
    wb_read("head_q_first", 32'h3000_0024, 32'h100);
    wb_read("head_r_first", 32'h3000_0028, 32'h200);
    wb_write("clr_ovf", 32'h3000_0020, 32'h0000_0100);
    wb_read("status_clr", 32'h3000_0020, 32'h0000_0044);

    // Pop coincident with a push while full
    @(negedge clk_i);
    fini_i = 1'b1; quotient_i = 32'h1FF; remainder_i = 32'h2FF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h3000_002C;
    @(negedge clk_i);
    fini_i = 1'b0;
    check("coinc_ack", 32'(wbs_ack_o), 32'h1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wb_read("status_coinc", 32'h3000_0020, 32'h0000_0044);
    exp_q = '{32'h101, 32'h102, 32'h103, 32'h1FF};
    for (int i = 0; i < 4; i++) begin
      wb_read("drain_head_q", 32'h3000_0024, exp_q[i]);
      wb_read("drain_pop_rd", 32'h3000_002C, 32'h0);
    end
    wb_read("status_after_drain", 32'h3000_0020, 32'h0000_0020);
    wb_write("pop_empty", 32'h3000_002C, 32'h0);

    // Unmapped offsets inside the window
    wb_read("bad_0x21", 32'h3000_0021, 32'h0bad_0bad);
    wb_read("bad_0x2e", 32'h3000_002E, 32'h0bad_0bad);

    // Interrupt enable and release
    fini_pulse(32'h77, 32'h5);
    wb_write("irq_en_wr", 32'h3000_0020, 32'h0001_0000);
    check("irq_at_ack", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    check("irq_set", 32'(irq_o), 32'h1);
    wb_write("irq_pop", 32'h3000_002C, 32'h0);
    check("irq_still_at_ack", 32'(irq_o), 32'h1);
    @(negedge clk_i);
    check("irq_cleared", 32'(irq_o), 32'h0);

    // Asynchronous reset in the middle of a transfer
    for (int i = 0; i < 3; i++) fini_pulse(32'h40 + i, 32'h50 + i);
    @(negedge clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0024;
    @(posedge clk_i);
    #2;
    check("pre_rst_ack", 32'(wbs_ack_o), 32'h1);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    reset_ni = 1'b0;
    #1;
    check("rst_ack_drop", 32'(wbs_ack_o), 32'h0);
    check("rst_irq_drop", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    wb_read("status_after_rst", 32'h3000_0020, 32'h0000_0020);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_i);
      if (i % 500 == 250) begin
        fini_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        continue;
      end
      if ($urandom_range(0, 5) == 0) fini_i = ~fini_i;
      quotient_i  = $urandom;
      remainder_i = $urandom;
      wbs_stb_i = ($urandom_range(0, 9) < 7);
      wbs_cyc_i = ($urandom_range(0, 9) < 9);
      wbs_we_i  = ($urandom_range(0, 1) == 1);
      wbs_dat_i = $urandom;
      case ($urandom_range(0, 5))
        0:       o = 4'h0;
        1:       o = 4'h4;
        2:       o = 4'h8;
        default: o = 4'hC;
      endcase
      case ($urandom_range(0, 9))
        6:       wbs_adr_i = 32'h3000_0020 | 32'($urandom_range(0, 15));
        7:       wbs_adr_i = 32'h3ABC_DE20 | 32'(o);
        8:       wbs_adr_i = 32'h3000_0030 | 32'(o);
        9:       wbs_adr_i = 32'h2000_0020 | 32'(o);
        default: wbs_adr_i = 32'h3000_0020 | 32'(o);
      endcase
    end
    @(negedge clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; fini_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
